instruction_decode: RTL and testbench

- Pipeline stage directly downstream of instruction fetch.
- Registers each valid fetched RV64I instruction and decodes it into register indices, a 64-bit immediate, an op class and function bits for execute.
- Drives register-file read addresses combinationally.
- Detects load-use hazards against the instruction it last issued, and flushes on branch reset.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/decode_comb.sv | 64 ++++++
 rtl/instruction_decode.sv | 141 ++++++++++++++
 tb/tb_instruction_decode.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and opcode constants for the RV64I core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   typedef logic [63:0] double_word;

   typedef enum logic [3:0] {
      LUI,
      AUIPC,
      JAL,
      JALR,
      BRANCH,
      LOAD,
      STORE,
      OPIMM,
      OP,
      OPIMM32,
      OP32,
      FENCE,
      SYSTEM,
      ILLEGAL
   } op_class_t;

   localparam logic [6:0] C_OPC_LUI     = 7'b0110111;
   localparam logic [6:0] C_OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] C_OPC_JAL     = 7'b1101111;
   localparam logic [6:0] C_OPC_JALR    = 7'b1100111;
   localparam logic [6:0] C_OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] C_OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] C_OPC_STORE   = 7'b0100011;
   localparam logic [6:0] C_OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] C_OPC_OP      = 7'b0110011;
   localparam logic [6:0] C_OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] C_OPC_OP32    = 7'b0111011;
   localparam logic [6:0] C_OPC_FENCE   = 7'b0001111;
   localparam logic [6:0] C_OPC_SYSTEM  = 7'b1110011;

endpackage
`default_nettype wire

// File: rtl/decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : decode_comb
// Description : Purely combinational RV64I decoder: op class, immediate,
//               register-use flags. Shared by issue and hazard logic.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_comb
   import cpu_pkg::*;
(
   input  logic [31:0] instruction,
   output op_class_t   op_class,
   output double_word  imm,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic        writes_rd
);

   logic [63:0] w_imm_i;
   logic [63:0] w_imm_s;
   logic [63:0] w_imm_b;
   logic [63:0] w_imm_u;
   logic [63:0] w_imm_j;
   logic        w_class_writes;

   assign w_imm_i = {{52{instruction[31]}}, instruction[31:20]};
   assign w_imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign w_imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
   assign w_imm_u = {{32{instruction[31]}}, instruction[31:12], 12'b0};
   assign w_imm_j = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};

   // Opcode lookup; all legal opcodes end in 2'b11 so the default catches both
   // unknown opcodes and compressed/invalid encodings.
   always_comb begin
      op_class       = ILLEGAL;
      imm            = '0;
      uses_rs1       = 1'b0;
      uses_rs2       = 1'b0;
      w_class_writes = 1'b0;
      case (instruction[6:0])
         C_OPC_LUI:     begin op_class = LUI;     imm = w_imm_u; w_class_writes = 1'b1; end
         C_OPC_AUIPC:   begin op_class = AUIPC;   imm = w_imm_u; w_class_writes = 1'b1; end
         C_OPC_JAL:     begin op_class = JAL;     imm = w_imm_j; w_class_writes = 1'b1; end
         C_OPC_JALR:    begin op_class = JALR;    imm = w_imm_i; w_class_writes = 1'b1; uses_rs1 = 1'b1; end
         C_OPC_BRANCH:  begin op_class = BRANCH;  imm = w_imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         C_OPC_LOAD:    begin op_class = LOAD;    imm = w_imm_i; w_class_writes = 1'b1; uses_rs1 = 1'b1; end
         C_OPC_STORE:   begin op_class = STORE;   imm = w_imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         C_OPC_OPIMM:   begin op_class = OPIMM;   imm = w_imm_i; w_class_writes = 1'b1; uses_rs1 = 1'b1; end
         C_OPC_OP:      begin op_class = OP;      w_class_writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         C_OPC_OPIMM32: begin op_class = OPIMM32; imm = w_imm_i; w_class_writes = 1'b1; uses_rs1 = 1'b1; end
         C_OPC_OP32:    begin op_class = OP32;    w_class_writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         C_OPC_FENCE:   begin op_class = FENCE;   w_class_writes = 1'b1; end
         C_OPC_SYSTEM:  begin op_class = SYSTEM;  imm = w_imm_i; w_class_writes = 1'b1; end
         default:       begin op_class = ILLEGAL; end
      endcase
   end

   // x0 is never a real destination, so it can neither be written nor cause a hazard.
   assign writes_rd = w_class_writes && (instruction[11:7] != 5'd0);

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode
// Description : RV64I decode stage. Registers decoded fetch output, drives
//               regfile read addresses, inserts a bubble on load-use hazards
//               and squashes on forwarded branch reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode
   import cpu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [31:0]     in_instruction,
   input  logic [XLEN-1:0] in_pc,
   input  logic            stall_in,
   input  logic            branch_reset_in,
   output logic            stall_out,
   output logic            branch_reset_out,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic            out_valid,
   output logic [XLEN-1:0] out_pc,
   output op_class_t       out_op_class,
   output logic [2:0]      out_funct3,
   output logic            out_alt,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic            out_uses_rs1,
   output logic            out_uses_rs2,
   output logic            out_writes_rd,
   output logic [XLEN-1:0] out_imm
);

   generate
      if (XLEN != 64) begin : g_xlen_check
         $error("instruction_decode: only XLEN=64 is supported");
      end
   endgenerate

   op_class_t  w_op_class;
   double_word w_imm;
   logic       w_uses_rs1;
   logic       w_uses_rs2;
   logic       w_writes_rd;
   logic       w_hazard;

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   op_class_t       r_op_class;
   logic [2:0]      r_funct3;
   logic            r_alt;
   logic [4:0]      r_rd;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic            r_uses_rs1;
   logic            r_uses_rs2;
   logic            r_writes_rd;
   logic [XLEN-1:0] r_imm;
   logic            r_branch_reset;

   decode_comb u_decode (
      .instruction (in_instruction),
      .op_class    (w_op_class),
      .imm         (w_imm),
      .uses_rs1    (w_uses_rs1),
      .uses_rs2    (w_uses_rs2),
      .writes_rd   (w_writes_rd)
   );

   assign rs1_addr = in_instruction[19:15];
   assign rs2_addr = in_instruction[24:20];

   // Load-use: the incoming instruction reads the register the issued load writes.
   assign w_hazard = in_valid && r_valid && (r_op_class == LOAD) && r_writes_rd &&
                     ((w_uses_rs1 && (in_instruction[19:15] == r_rd)) ||
                      (w_uses_rs2 && (in_instruction[24:20] == r_rd)));

   assign stall_out = (stall_in || w_hazard) && !branch_reset_in;

   // Issue register: branch reset squashes, stall holds, hazard bubbles, else load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid        <= 1'b0;
         r_pc           <= '0;
         r_op_class     <= LUI;
         r_funct3       <= '0;
         r_alt          <= 1'b0;
         r_rd           <= '0;
         r_rs1          <= '0;
         r_rs2          <= '0;
         r_uses_rs1     <= 1'b0;
         r_uses_rs2     <= 1'b0;
         r_writes_rd    <= 1'b0;
         r_imm          <= '0;
         r_branch_reset <= 1'b0;
      end else begin
         r_branch_reset <= branch_reset_in;
         if (branch_reset_in) begin
            r_valid <= 1'b0;
         end else if (stall_in) begin
            r_valid <= r_valid;
         end else if (w_hazard) begin
            r_valid <= 1'b0;
         end else begin
            r_valid     <= in_valid;
            r_pc        <= in_pc;
            r_op_class  <= w_op_class;
            r_funct3    <= in_instruction[14:12];
            r_alt       <= in_instruction[30];
            r_rd        <= in_instruction[11:7];
            r_rs1       <= in_instruction[19:15];
            r_rs2       <= in_instruction[24:20];
            r_uses_rs1  <= w_uses_rs1;
            r_uses_rs2  <= w_uses_rs2;
            r_writes_rd <= w_writes_rd;
            r_imm       <= w_imm;
         end
      end
   end

   assign out_valid        = r_valid;
   assign out_pc           = r_pc;
   assign out_op_class     = r_op_class;
   assign out_funct3       = r_funct3;
   assign out_alt          = r_alt;
   assign out_rd           = r_rd;
   assign out_rs1          = r_rs1;
   assign out_rs2          = r_rs2;
   assign out_uses_rs1     = r_uses_rs1;
   assign out_uses_rs2     = r_uses_rs2;
   assign out_writes_rd    = r_writes_rd;
   assign out_imm          = r_imm;
   assign branch_reset_out = r_branch_reset;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decode
// Description : Self-checking bench for instruction_decode: directed scenarios
//               followed by random traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instruction;
   logic [63:0] in_pc;
   logic        stall_in;
   logic        branch_reset_in;
   logic        stall_out;
   logic        branch_reset_out;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        out_valid;
   logic [63:0] out_pc;
   op_class_t   out_op_class;
   logic [2:0]  out_funct3;
   logic        out_alt;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic        out_uses_rs1;
   logic        out_uses_rs2;
   logic        out_writes_rd;
   logic [63:0] out_imm;

   always #5 clk = ~clk;

   instruction_decode #(.XLEN(64)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_instruction   (in_instruction),
      .in_pc            (in_pc),
      .stall_in         (stall_in),
      .branch_reset_in  (branch_reset_in),
      .stall_out        (stall_out),
      .branch_reset_out (branch_reset_out),
      .rs1_addr         (rs1_addr),
      .rs2_addr         (rs2_addr),
      .out_valid        (out_valid),
      .out_pc           (out_pc),
      .out_op_class     (out_op_class),
      .out_funct3       (out_funct3),
      .out_alt          (out_alt),
      .out_rd           (out_rd),
      .out_rs1          (out_rs1),
      .out_rs2          (out_rs2),
      .out_uses_rs1     (out_uses_rs1),
      .out_uses_rs2     (out_uses_rs2),
      .out_writes_rd    (out_writes_rd),
      .out_imm          (out_imm)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      op_class_t cls;
      bit        u1;
      bit        u2;
      bit        wr;
      longint    imm;
   } ref_t;

   // Reference model state: what the issued bundle should look like.
   bit        m_valid, m_known, m_brout, m_alt, m_u1, m_u2, m_wr;
   op_class_t m_cls;
   logic [63:0] m_pc, m_imm;
   logic [2:0]  m_f3;
   logic [4:0]  m_rd, m_rs1, m_rs2;
   bit          last_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Table of opcode -> class, immediate format and register usage; immediates
   // are then built arithmetically from a sign-extended copy of the word.
   function automatic ref_t ref_decode(input logic [31:0] ins);
      ref_t   r;
      byte    fmt;
      bit     wcls;
      longint s;
      r.cls = ILLEGAL; r.u1 = 0; r.u2 = 0; wcls = 0; fmt = "N";
      case (ins[6:0])
         7'b0110111: begin r.cls = LUI;     fmt = "U"; wcls = 1; end
         7'b0010111: begin r.cls = AUIPC;   fmt = "U"; wcls = 1; end
         7'b1101111: begin r.cls = JAL;     fmt = "J"; wcls = 1; end
         7'b1100111: begin r.cls = JALR;    fmt = "I"; wcls = 1; r.u1 = 1; end
         7'b1100011: begin r.cls = BRANCH;  fmt = "B"; r.u1 = 1; r.u2 = 1; end
         7'b0000011: begin r.cls = LOAD;    fmt = "I"; wcls = 1; r.u1 = 1; end
         7'b0100011: begin r.cls = STORE;   fmt = "S"; r.u1 = 1; r.u2 = 1; end
         7'b0010011: begin r.cls = OPIMM;   fmt = "I"; wcls = 1; r.u1 = 1; end
         7'b0110011: begin r.cls = OP;      wcls = 1; r.u1 = 1; r.u2 = 1; end
         7'b0011011: begin r.cls = OPIMM32; fmt = "I"; wcls = 1; r.u1 = 1; end
         7'b0111011: begin r.cls = OP32;    wcls = 1; r.u1 = 1; r.u2 = 1; end
         7'b0001111: begin r.cls = FENCE;   wcls = 1; end
         7'b1110011: begin r.cls = SYSTEM;  fmt = "I"; wcls = 1; end
         default:    begin r.cls = ILLEGAL; end
      endcase
      s = longint'($signed(ins));
      case (fmt)
         "I":     r.imm = s >>> 20;
         "S":     r.imm = ((s >>> 25) << 5) | longint'(ins[11:7]);
         "B":     r.imm = ((s >>> 31) << 12) | (longint'(ins[7]) << 11) |
                          (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
         "U":     r.imm = (s >>> 12) << 12;
         "J":     r.imm = ((s >>> 31) << 20) | (longint'(ins[19:12]) << 12) |
                          (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
         default: r.imm = 0;
      endcase
      r.wr = wcls && (ins[11:7] != 5'd0);
      return r;
   endfunction

   task automatic check_outputs();
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("branch_reset_out", 64'(branch_reset_out), 64'(m_brout));
      if (m_known) begin
         chk("out_pc", out_pc, m_pc);
         chk("out_op_class", 64'(out_op_class), 64'(m_cls));
         chk("out_funct3", 64'(out_funct3), 64'(m_f3));
         chk("out_alt", 64'(out_alt), 64'(m_alt));
         chk("out_rd", 64'(out_rd), 64'(m_rd));
         chk("out_rs1", 64'(out_rs1), 64'(m_rs1));
         chk("out_rs2", 64'(out_rs2), 64'(m_rs2));
         chk("out_uses_rs1", 64'(out_uses_rs1), 64'(m_u1));
         chk("out_uses_rs2", 64'(out_uses_rs2), 64'(m_u2));
         chk("out_writes_rd", 64'(out_writes_rd), 64'(m_wr));
         chk("out_imm", out_imm, m_imm);
      end
   endtask

   // One clock with inputs already driven (called just after a falling edge).
   task automatic cycle();
      ref_t d;
      bit   hz, es;
      #1;
      d  = ref_decode(in_instruction);
      hz = in_valid && m_valid && (m_cls == LOAD) && m_wr &&
           ((d.u1 && in_instruction[19:15] == m_rd) || (d.u2 && in_instruction[24:20] == m_rd));
      es = (stall_in || hz) && !branch_reset_in;
      last_stall = es;
      chk("stall_out", 64'(stall_out), 64'(es));
      chk("rs1_addr", 64'(rs1_addr), 64'(in_instruction[19:15]));
      chk("rs2_addr", 64'(rs2_addr), 64'(in_instruction[24:20]));
      @(posedge clk);
      m_brout = branch_reset_in;
      if (branch_reset_in || (!stall_in && hz)) begin
         m_valid = 0;
         m_known = 0;
      end else if (!stall_in) begin
         m_valid = in_valid;  m_known = 1;
         m_pc    = in_pc;     m_cls   = d.cls;
         m_f3    = in_instruction[14:12];
         m_alt   = in_instruction[30];
         m_rd    = in_instruction[11:7];
         m_rs1   = in_instruction[19:15];
         m_rs2   = in_instruction[24:20];
         m_u1    = d.u1;      m_u2    = d.u2;
         m_wr    = d.wr;      m_imm   = d.imm;
      end
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                        input bit st, input bit br);
      in_valid = v; in_instruction = ins; in_pc = pc; stall_in = st; branch_reset_in = br;
   endtask

   logic [6:0]  ops [13] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0011011,
                             7'b0111011, 7'b0001111, 7'b1110011};
   logic [31:0] rnd;
   logic [63:0] held_pc;

   initial begin
      // Reset dominates any input activity.
      rst = 1'b1;
      drive(1, 32'hFFF08293, 64'h1234, 0, 1);
      @(posedge clk); @(posedge clk); #1;
      m_valid = 0; m_known = 1; m_brout = 0; m_pc = 0; m_cls = LUI; m_f3 = 0; m_alt = 0;
      m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_u1 = 0; m_u2 = 0; m_wr = 0; m_imm = 0;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;

      // addi x5,x1,-1
      drive(1, 32'hFFF08293, 64'h1000, 0, 0);
      cycle();
      chk("addi_class", 64'(out_op_class), 64'(OPIMM));
      chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

      // ld x6,0(x2) then add x7,x6,x1: one stall, one bubble, then issue
      drive(1, 32'h00013303, 64'h1004, 0, 0);
      cycle();
      drive(1, 32'h001303B3, 64'h1008, 0, 0);
      cycle();
      chk("hazard_stall", 64'(last_stall), 64'd1);
      chk("hazard_bubble", 64'(out_valid), 64'd0);
      cycle();
      chk("hazard_once", 64'(last_stall), 64'd0);
      chk("add_rs1", 64'(out_rs1), 64'd6);
      chk("add_rs2", 64'(out_rs2), 64'd1);

      // Downstream stall holds the issued bundle for three cycles
      drive(1, 32'h00A00513, 64'h2000, 0, 0);
      cycle();
      held_pc = 64'h2000;
      drive(1, 32'h00B00593, 64'h2004, 1, 0);
      for (int i = 0; i < 3; i++) cycle();
      chk("stall_hold_pc", out_pc, held_pc);

      // Branch reset while stalled squashes and suppresses stall_out
      drive(1, 32'h00B00593, 64'h2004, 1, 1);
      cycle();
      chk("br_stall_out", 64'(last_stall), 64'd0);
      drive(0, 32'h0, 64'h0, 0, 0);
      cycle();

      // beq x0,x0,-4
      drive(1, 32'hFE000EE3, 64'h3000, 0, 0);
      cycle();
      chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

      // All-zero word is illegal but still valid
      drive(1, 32'h00000000, 64'h3004, 0, 0);
      cycle();
      chk("illegal_class", 64'(out_op_class), 64'(ILLEGAL));

      // Random traffic; fetch holds its word while stall_out is high
      for (int n = 0; n < 400; n++) begin
         if (!last_stall) begin
            rnd = $urandom;
            if ($urandom_range(0, 15) < 13) rnd[6:0] = ops[$urandom_range(0, 12)];
            if ($urandom_range(0, 9) < 7) begin
               rnd[11:7]  = 5'(rnd[8:7]);
               rnd[19:15] = 5'(rnd[16:15]);
               rnd[24:20] = 5'(rnd[21:20]);
            end
            in_instruction = rnd;
            in_pc          = {$urandom, $urandom};
            in_valid       = ($urandom_range(0, 9) < 8);
         end
         stall_in        = ($urandom_range(0, 9) < 2);
         branch_reset_in = ($urandom_range(0, 19) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
